inst_fetch: RTL

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_pkg.sv | 27 ++
 rtl/inst_fetch_if.sv | 27 ++
 rtl/inst_fetch_fifo.sv | 51 +++++
 rtl/inst_fetch.sv | 104 ++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared types and sizing for the instruction fetch unit.
package inst_fetch_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned FIFO_PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DROP = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction-memory, decode and redirect signals of the fetch unit.
interface inst_fetch_if;
  import inst_fetch_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] instruction;
  logic [XLEN-1:0] inst_pc;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, inst_valid, instruction, inst_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, inst_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, instruction, inst_pc,
    output imem_gnt, imem_rvalid, imem_rdata, inst_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/inst_fetch_fifo.sv
// Two-entry instruction/PC buffer with flush; head is presented to decode.
module fetch_fifo import inst_fetch_pkg::*; (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_flush,
  input  logic                  i_push,
  input  fetch_entry_t          i_data,
  input  logic                  i_pop,
  output fetch_entry_t          o_head,
  output logic                  o_empty,
  output logic [FIFO_CNT_W-1:0] o_count
);

  fetch_entry_t          r_mem [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] r_rd_ptr;
  logic [FIFO_PTR_W-1:0] r_wr_ptr;
  logic [FIFO_CNT_W-1:0] r_count;

  logic w_pop;
  logic w_push;
  logic w_full;

  assign w_full = (r_count == FIFO_CNT_W'(FIFO_DEPTH));
  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && (!w_full || w_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + FIFO_PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + FIFO_PTR_W'(1);
      r_count <= r_count + FIFO_CNT_W'(w_push) - FIFO_CNT_W'(w_pop);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: one outstanding memory request, 2-entry decode buffer,
// credit-based issue and redirect flush with stale-response dropping.
module inst_fetch import inst_fetch_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic         clk,
  input  logic         rst,
  inst_fetch_if.master bus
);

  fetch_state_t    r_state;
  logic            r_imem_req;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_req_addr;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_empty;
  logic                  w_room;
  logic [FIFO_CNT_W-1:0] w_count;
  fetch_entry_t          w_entry;
  fetch_entry_t          w_head;

  assign w_pop   = !w_empty && bus.inst_ready;
  assign w_push  = (r_state == S_WAIT) && bus.imem_rvalid && !bus.redirect;
  assign w_entry = '{inst: bus.imem_rdata, pc: r_req_addr};
  // Space still free once the pending response lands (pop this cycle counts).
  assign w_room  = (w_count == '0) || ((w_count == FIFO_CNT_W'(1)) && w_pop);

  fetch_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (bus.redirect),
    .i_push  (w_push),
    .i_data  (w_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_imem_req <= 1'b0;
      r_pc       <= align_pc(RESET_PC);
      r_req_addr <= align_pc(RESET_PC);
    end else if (bus.redirect) begin
      r_pc <= align_pc(bus.redirect_pc);
      case (r_state)
        S_IDLE: begin r_state <= S_REQ; r_imem_req <= 1'b1; end
        S_REQ: begin
          if (bus.imem_gnt) begin r_state <= S_DROP; r_imem_req <= 1'b0; end
          else              begin r_state <= S_REQ;  r_imem_req <= 1'b1; end
        end
        S_WAIT: begin
          if (bus.imem_rvalid) begin r_state <= S_REQ;  r_imem_req <= 1'b1; end
          else                 begin r_state <= S_DROP; r_imem_req <= 1'b0; end
        end
        // A response arriving with the new redirect is the one being dropped.
        S_DROP: begin
          if (bus.imem_rvalid) begin r_state <= S_REQ;  r_imem_req <= 1'b1; end
          else                 begin r_state <= S_DROP; r_imem_req <= 1'b0; end
        end
      endcase
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_count != FIFO_CNT_W'(FIFO_DEPTH)) begin
            r_state    <= S_REQ;
            r_imem_req <= 1'b1;
          end
        end
        S_REQ: begin
          if (bus.imem_gnt) begin
            r_state    <= S_WAIT;
            r_imem_req <= 1'b0;
            r_req_addr <= r_pc;
            r_pc       <= r_pc + XLEN'(4);
          end
        end
        S_WAIT: begin
          if (bus.imem_rvalid) begin
            r_state    <= w_room ? S_REQ : S_IDLE;
            r_imem_req <= w_room;
          end
        end
        S_DROP: begin
          if (bus.imem_rvalid) begin
            r_state    <= S_REQ;
            r_imem_req <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.imem_req    = r_imem_req;
  assign bus.imem_addr   = r_pc;
  assign bus.inst_valid  = !w_empty;
  assign bus.instruction = w_head.inst;
  assign bus.inst_pc     = w_head.pc;

endmodule
